// File: rtl/test_reg_bank.sv
// Avalon-MM test register bank: ID word, byte-writable scratch registers,
// a free-running cycle counter and a saturating scratch-write counter.
module test_reg_bank #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = 16'h5a5a,
  parameter logic [DATA_W-1:0] ID_VALUE  = 16'hc0de
) (
  input  logic                csi_MCLK_clk,
  input  logic                rsi_MRST_reset_n,
  input  logic [ADDR_W-1:0]   avs_TestReg_address,
  input  logic [DATA_W-1:0]   avs_TestReg_writedata,
  input  logic [DATA_W/8-1:0] avs_TestReg_byteenable,
  input  logic                avs_TestReg_write,
  input  logic                avs_TestReg_read,
  output logic [DATA_W-1:0]   avs_TestReg_readdata,
  output logic                avs_TestReg_readdatavalid
);

  localparam int NBYTES  = DATA_W / 8;
  localparam int LAST_SC = NUM_REGS - 3;
  localparam int CYC_A   = NUM_REGS - 2;
  localparam int WCNT_A  = NUM_REGS - 1;

  logic [DATA_W-1:0] scratch [1:LAST_SC];
  logic [DATA_W-1:0] cycCnt;
  logic [DATA_W-1:0] wrCnt;
  logic [DATA_W-1:0] rdMux;
  int                addrI;
  logic              anyBe;
  logic              isScratch;
  logic              wrScratch;

  assign addrI     = 32'(avs_TestReg_address);
  assign anyBe     = |avs_TestReg_byteenable;
  assign isScratch = (addrI >= 1) && (addrI <= LAST_SC);
  assign wrScratch = avs_TestReg_write && isScratch && anyBe;

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      for (int r = 1; r <= LAST_SC; r++) scratch[r] <= RESET_VAL;
    end else if (avs_TestReg_write) begin
      for (int r = 1; r <= LAST_SC; r++) begin
        if (addrI == r) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (avs_TestReg_byteenable[b])
              scratch[r][8*b +: 8] <= avs_TestReg_writedata[8*b +: 8];
          end
        end
      end
    end
  end

  // A clearing write wins over the increment on the same edge.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n)
      cycCnt <= '0;
    else if (avs_TestReg_write && (addrI == CYC_A) && anyBe)
      cycCnt <= '0;
    else
      cycCnt <= cycCnt + DATA_W'(1);
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n)
      wrCnt <= '0;
    else if (avs_TestReg_write && (addrI == WCNT_A) && anyBe)
      wrCnt <= '0;
    else if (wrScratch && (wrCnt != '1))
      wrCnt <= wrCnt + DATA_W'(1);
  end

  always_comb begin
    rdMux = '0;
    if (addrI == 0) rdMux = ID_VALUE;
    for (int r = 1; r <= LAST_SC; r++) begin
      if (addrI == r) rdMux = scratch[r];
    end
    if (addrI == CYC_A)  rdMux = cycCnt;
    if (addrI == WCNT_A) rdMux = wrCnt;
  end

  // Read handshake: a read sampled on an edge is answered with readdatavalid
  // high for exactly the following cycle, carrying the pre-edge register value;
  // there is no waitrequest, and readdata holds its last value otherwise.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      avs_TestReg_readdata      <= '0;
      avs_TestReg_readdatavalid <= 1'b0;
    end else begin
      avs_TestReg_readdatavalid <= avs_TestReg_read;
      if (avs_TestReg_read) avs_TestReg_readdata <= rdMux;
    end
  end

endmodule

// File: tb/tb_test_reg_bank.sv
// Randomised and directed bench for test_reg_bank with a register-file
// reference model and a queue-based read-response scoreboard.
module tb_test_reg_bank;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;
  localparam int NB = DW / 8;
  localparam logic [DW-1:0] RST_V = 16'h5a5a;
  localparam logic [DW-1:0] ID_V  = 16'hc0de;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] writedata = '0;
  logic [NB-1:0] byteenable = '0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] readdata;
  logic          readdatavalid;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_t[$];
  logic [DW-1:0] last_data = '0;

  // Reference: one word per address; index NR-2 is the cycle counter,
  // NR-1 the write counter.
  logic [DW-1:0] m_reg [NR];

  test_reg_bank dut (
    .csi_MCLK_clk              (clk),
    .rsi_MRST_reset_n          (rst_n),
    .avs_TestReg_address       (address),
    .avs_TestReg_writedata     (writedata),
    .avs_TestReg_byteenable    (byteenable),
    .avs_TestReg_write         (write),
    .avs_TestReg_read          (read),
    .avs_TestReg_readdata      (readdata),
    .avs_TestReg_readdatavalid (readdatavalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at cycle %0d", name, act, exp, tb_cyc);
    end
  endtask

  task automatic m_reset();
    for (int a = 0; a < NR; a++) m_reg[a] = RST_V;
    m_reg[0]    = ID_V;
    m_reg[NR-2] = '0;
    m_reg[NR-1] = '0;
  endtask

  function automatic logic [DW-1:0] m_read(input int a);
    if (a >= NR) return '0;
    return m_reg[a];
  endfunction

  task automatic m_step(input logic wr, input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    logic [DW-1:0] nxt [NR];
    nxt = m_reg;
    nxt[NR-2] = m_reg[NR-2] + 1'b1;
    if (wr && be != 0 && a < NR) begin
      if (a >= 1 && a <= NR-3) begin
        for (int b = 0; b < NB; b++)
          if (be[b]) nxt[a][8*b +: 8] = d[8*b +: 8];
        if (m_reg[NR-1] != {DW{1'b1}}) nxt[NR-1] = m_reg[NR-1] + 1'b1;
      end else if (a == NR-2) begin
        nxt[NR-2] = '0;
      end else if (a == NR-1) begin
        nxt[NR-1] = '0;
      end
    end
    m_reg = nxt;
  endtask

  // Drives one bus cycle starting at a falling edge, predicts, then advances.
  task automatic bus_cycle(input logic rd, input logic wr, input int a,
                           input logic [DW-1:0] d, input logic [NB-1:0] be);
    read       = rd;
    write      = wr;
    address    = AW'(a);
    writedata  = d;
    byteenable = be;
    if (rd) begin
      exp_q.push_back(m_read(a));
      exp_t.push_back(tb_cyc + 1);
    end
    m_step(wr, a, d, be);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    exp_t.delete();
    last_data = '0;
    m_reset();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (readdatavalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid: got readdatavalid=1 expected 0 at cycle %0d", tb_cyc);
      end else begin
        logic [DW-1:0] e;
        int t;
        e = exp_q.pop_front();
        t = exp_t.pop_front();
        chk("readdata", readdata, e);
        checks++;
        if (t != tb_cyc) begin
          errors++;
          $display("FAIL latency: valid at cycle %0d expected %0d", tb_cyc, t);
        end
        last_data = e;
      end
    end else begin
      chk("readdata_hold", readdata, last_data);
      if (exp_q.size() != 0 && exp_t[0] <= tb_cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_valid: got readdatavalid=0 expected 1 (data 0x%h) at cycle %0d",
                 exp_q[0], tb_cyc);
        void'(exp_q.pop_front());
        void'(exp_t.pop_front());
      end
    end
  end

  initial begin
    assert_reset();
    @(negedge clk);
    release_reset();

    // Reset contents across the whole map.
    for (int a = 0; a < NR; a++) bus_cycle(1'b1, 1'b0, a, '0, '0);

    // Upper-byte-only scratch write, then read it and the write counter.
    bus_cycle(1'b0, 1'b1, 2, 16'h1234, 2'b10);
    bus_cycle(1'b1, 1'b0, 2, '0, '0);
    bus_cycle(1'b1, 1'b0, 7, '0, '0);

    // Cycle counter clear and restart.
    bus_cycle(1'b0, 1'b1, 6, 16'hffff, 2'b11);
    bus_cycle(1'b1, 1'b0, 6, '0, '0);
    bus_cycle(1'b1, 1'b0, 6, '0, '0);

    // Writes to the ID word are ignored.
    bus_cycle(1'b0, 1'b1, 0, 16'h0bad, 2'b11);
    bus_cycle(1'b1, 1'b0, 0, '0, '0);

    // Simultaneous read and write: read sees pre-write contents.
    bus_cycle(1'b1, 1'b1, 3, 16'hbeef, 2'b11);
    bus_cycle(1'b1, 1'b0, 3, '0, '0);

    for (int i = 0; i < 400; i++)
      bus_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, NR-1), DW'($urandom), NB'($urandom_range(0, 3)));

    // Saturate the write counter; reads of the cycle counter straddle its wrap.
    bus_cycle(1'b0, 1'b1, 6, '0, 2'b01);
    for (int i = 0; i < 65546; i++) begin
      if (i >= 65530 && i <= 65536)
        bus_cycle(1'b1, 1'b0, 6, '0, '0);
      else
        bus_cycle(1'b0, 1'b1, $urandom_range(1, NR-3), DW'($urandom), NB'($urandom_range(1, 3)));
    end
    bus_cycle(1'b1, 1'b0, 7, '0, '0);
    bus_cycle(1'b0, 1'b1, 7, '0, 2'b01);
    bus_cycle(1'b1, 1'b0, 7, '0, '0);

    // Read sampled, then reset before its valid cycle is observed.
    read = 1'b1;
    address = AW'(4);
    @(posedge clk);
    #1;
    assert_reset();
    @(negedge clk);
    release_reset();
    for (int a = 0; a < NR; a++) bus_cycle(1'b1, 1'b0, a, '0, '0);
    bus_cycle(1'b0, 1'b1, 1, 16'h7777, 2'b00);
    bus_cycle(1'b1, 1'b0, 7, '0, '0);
    bus_cycle(1'b1, 1'b0, 1, '0, '0);

    for (int i = 0; i < 200; i++)
      bus_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, NR-1), DW'($urandom), NB'($urandom_range(0, 3)));

    idle_inputs();
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
